// File: rtl/commutator_ctrl.sv
// commutator_ctrl: five-phase Moore sequencer that drives one MDC-stage input commutator
module commutator_ctrl #(
    parameter int DEPTH = 8,
    parameter int CW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          abort,
    input  logic          in_valid,
    output logic          mode,
    output logic          flag_in_com1,
    output logic          flag_in_com2,
    output logic          flag_switch_state2,
    output logic          out_valid,
    output logic          busy,
    output logic          done,
    output logic [CW-1:0] phase_cnt
);
    typedef enum logic [2:0] {IDLE, LOAD_UP, LOAD_LOW, PASS, SWAP, DRAIN, DONE} state_t;
    state_t state, state_nx;
    logic [CW-1:0] cnt_nx;
    logic step, last;
    assign last = phase_cnt == CW'(DEPTH - 1);
    // State and phase counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            phase_cnt <= '0;
        end else begin
            state <= state_nx;
            phase_cnt <= cnt_nx;
        end
    end
    // Next state: input phases consume on in_valid, DRAIN flushes every cycle, abort wins
    always_comb begin
        step = 1'b0;
        state_nx = state;
        cnt_nx = phase_cnt;
        case (state)
            IDLE: state_nx = start ? LOAD_UP : IDLE;
            LOAD_UP, LOAD_LOW, PASS, SWAP: step = in_valid;
            DRAIN: step = 1'b1;
            default: state_nx = IDLE;
        endcase
        if (step) begin
            cnt_nx = last ? '0 : phase_cnt + 1'b1;
            state_nx = last ? state_t'(state + 3'd1) : state;
        end
        if (abort) begin
            state_nx = IDLE;
            cnt_nx = '0;
        end
    end
    assign mode = state inside {IDLE, LOAD_UP, LOAD_LOW, DONE};
    assign flag_in_com1 = state inside {LOAD_LOW, PASS, SWAP, DRAIN};
    assign flag_in_com2 = state inside {SWAP, DRAIN};
    assign flag_switch_state2 = state == DRAIN;
    assign out_valid = (state == SWAP && in_valid) || state == DRAIN;
    assign busy = state != IDLE;
    assign done = state == DONE;
endmodule

// File: tb/tb_commutator_ctrl.sv
// tb_commutator_ctrl: directed vector bench for commutator_ctrl at DEPTH=8 and DEPTH=2
module tb_commutator_ctrl;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n, start, abort, in_valid;
    logic mode, c1, c2, sw2, ov, busy, done;
    logic [2:0] pc;
    logic start2, abort2, in_valid2;
    logic m2, c1_2, c2_2, sw2_2, ov2, busy2, done2;
    logic [0:0] pc2;
    int errs = 0, checks = 0;

    commutator_ctrl #(.DEPTH(8)) u8 (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .in_valid(in_valid),
        .mode(mode), .flag_in_com1(c1), .flag_in_com2(c2), .flag_switch_state2(sw2),
        .out_valid(ov), .busy(busy), .done(done), .phase_cnt(pc)
    );
    commutator_ctrl #(.DEPTH(2)) u2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .abort(abort2), .in_valid(in_valid2),
        .mode(m2), .flag_in_com1(c1_2), .flag_in_com2(c2_2), .flag_switch_state2(sw2_2),
        .out_valid(ov2), .busy(busy2), .done(done2), .phase_cnt(pc2)
    );

    typedef struct {
        logic st;
        logic ab;
        logic iv;
        logic [9:0] exp;
    } vec_t;
    vec_t tbl[44];
    logic [3:0] ph[5] = '{4'b1000, 4'b1100, 4'b0100, 4'b0110, 4'b0111};
    localparam logic [9:0] IDLE_E = 10'b1000_000_000;

    function automatic logic [9:0] e(logic [3:0] f, logic o, logic b, logic d, logic [2:0] c);
        return {f, o, b, d, c};
    endfunction

    // Expected DEPTH=8 outputs for cycle c of a frame started at cycle 0 with in_valid held high
    function automatic logic [9:0] fexp(int c);
        if (c == 0 || c >= 42) return IDLE_E;
        if (c == 41) return e(4'b1000, 1'b0, 1'b1, 1'b1, 3'd0);
        return e(ph[(c - 1) / 8], c >= 25, 1'b1, 1'b0, 3'((c - 1) % 8));
    endfunction

    task automatic chk(string name, int got, int want);
        checks++;
        if (got != want) begin
            errs++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    task automatic check8(string name, logic [9:0] exp);
        logic [9:0] got;
        got = {mode, c1, c2, sw2, ov, busy, done, pc};
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %b want %b (flags,ov,busy,done,cnt)", name, got, exp);
        end
    endtask

    task automatic cyc(logic st, logic ab, logic iv, logic [9:0] exp, string name);
        @(posedge clk);
        #1;
        start = st;
        abort = ab;
        in_valid = iv;
        @(negedge clk);
        check8(name, exp);
    endtask

    initial begin
        int cnt_ph[5];
        int idx, bad_order, ov_bad, seen_done;
        logic [3:0] f;
        logic [7:0] got2, exp2;
        rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        in_valid = 1'b0;
        start2 = 1'b0;
        abort2 = 1'b0;
        in_valid2 = 1'b0;
        #12;
        check8("reset", IDLE_E);
        chk("reset_d2", {m2, c1_2, c2_2, sw2_2, ov2, busy2, done2, pc2}, 8'b1000_0000);
        @(negedge clk);
        rst_n = 1'b1;

        for (int c = 0; c < 44; c++) tbl[c] = '{st: c == 0, ab: 1'b0, iv: 1'b1, exp: fexp(c)};
        for (int c = 0; c < 44; c++) cyc(tbl[c].st, tbl[c].ab, tbl[c].iv, tbl[c].exp, $sformatf("frame_c%0d", c));

        cyc(1'b1, 1'b1, 1'b1, IDLE_E, "abort_start_idle");
        cyc(1'b0, 1'b0, 1'b1, IDLE_E, "stay_idle");
        for (int c = 0; c < 27; c++) cyc(c == 0, 1'b0, 1'b1, fexp(c), $sformatf("ab_c%0d", c));
        cyc(1'b0, 1'b1, 1'b1, e(4'b0110, 1'b1, 1'b1, 1'b0, 3'd2), "ab_swap3");
        cyc(1'b1, 1'b0, 1'b1, IDLE_E, "ab_idle");
        cyc(1'b0, 1'b0, 1'b1, e(4'b1000, 1'b0, 1'b1, 1'b0, 3'd0), "ab_restart");
        cyc(1'b0, 1'b1, 1'b1, e(4'b1000, 1'b0, 1'b1, 1'b0, 3'd1), "ab_load");
        cyc(1'b0, 1'b0, 1'b0, IDLE_E, "ab_clean");

        for (int c = 0; c < 43; c++)
            cyc(c == 0 || c == 20 || c == 41 || c == 42, 1'b0, 1'b1, fexp(c), $sformatf("ign_c%0d", c));
        cyc(1'b0, 1'b0, 1'b1, e(4'b1000, 1'b0, 1'b1, 1'b0, 3'd0), "ign_new_frame");
        cyc(1'b0, 1'b1, 1'b1, e(4'b1000, 1'b0, 1'b1, 1'b0, 3'd1), "ign_abort");
        cyc(1'b0, 1'b0, 1'b0, IDLE_E, "ign_clean");

        cnt_ph = '{0, 0, 0, 0, 0};
        idx = 0;
        bad_order = 0;
        ov_bad = 0;
        seen_done = 0;
        for (int k = 0; k < 100; k++) begin
            @(posedge clk);
            #1;
            start = k == 0;
            in_valid = k % 3 != 2;
            @(negedge clk);
            if (done) seen_done++;
            if (busy && !done) begin
                f = {mode, c1, c2, sw2};
                if (f != ph[idx] && idx < 4) idx++;
                if (f == ph[idx]) cnt_ph[idx]++;
                else bad_order++;
                if (f == 4'b0110 && ov !== in_valid) ov_bad++;
            end
            if (k > 0 && !busy) break;
        end
        for (int i = 0; i < 5; i++) chk($sformatf("gap_phase%0d_len", i), cnt_ph[i], i < 4 ? 12 : 8);
        chk("gap_order", bad_order, 0);
        chk("gap_swap_out_valid", ov_bad, 0);
        chk("gap_done_pulses", seen_done, 1);

        for (int c = 0; c < 14; c++) begin
            @(posedge clk);
            #1;
            start2 = c == 0;
            in_valid2 = 1'b1;
            @(negedge clk);
            exp2 = (c == 0 || c >= 12) ? 8'b1000_0000 :
                   c == 11 ? 8'b1000_0110 :
                   {ph[(c - 1) / 2], c >= 7, 1'b1, 1'b0, 1'((c - 1) % 2)};
            got2 = {m2, c1_2, c2_2, sw2_2, ov2, busy2, done2, pc2};
            chk($sformatf("d2_c%0d", c), got2, exp2);
        end

        for (int c = 0; c < 21; c++) cyc(c == 0, 1'b0, 1'b1, fexp(c), $sformatf("rst_c%0d", c));
        #2;
        rst_n = 1'b0;
        #1;
        check8("rst_async_mid_pass", IDLE_E);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(1'b0, 1'b0, 1'b1, IDLE_E, "post_rst");

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/commutator_ctrl.md
# commutator_ctrl

Sequencer that drives the control inputs of one MDC-stage input commutator in the 32-point FFT: `mode`, `flag_in_com1`, `flag_in_com2` and `flag_switch_state2`. It steps a frame through five phases (bypass fill of the upper path, bypass fill of the lower path, pass-through, swap, drain) by counting accepted samples. It sits between the stage input handshake and the commutator/delay-line pair, one instance per commutator stage.

## Interface

**Parameters**
- `DEPTH`, default 8: samples per phase, equal to the stage delay-line length; a power of two, ≥2.
- `CW`, default `$clog2(DEPTH)`: phase counter width.

**Ports**
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `start`, input, 1: frame start request; sampled only in IDLE.
- `abort`, input, 1: synchronous abort; returns the block to IDLE on the next edge.
- `in_valid`, input, 1: an input sample is present this cycle.
- `mode`, output, 1: commutator mode; 1 = bypass, 0 = switch.
- `flag_in_com1`, output, 1: commutator phase flag 1.
- `flag_in_com2`, output, 1: commutator phase flag 2.
- `flag_switch_state2`, output, 1: commutator final-phase flag.
- `out_valid`, output, 1: the commutator outputs hold a valid pair this cycle.
- `busy`, output, 1: high in every state except IDLE.
- `done`, output, 1: one-cycle pulse at the end of a frame.
- `phase_cnt`, output, CW: count of samples or cycles consumed in the current phase.

## Operation

- Moore FSM. States: IDLE, LOAD_UP, LOAD_LOW, PASS, SWAP, DRAIN, DONE.
- Outputs in each state, given as mode / com1 / com2 / sw2:
  - IDLE: 1/0/0/0
  - LOAD_UP: 1/0/0/0
  - LOAD_LOW: 1/1/0/0
  - PASS: 0/1/0/0
  - SWAP: 0/1/1/0
  - DRAIN: 0/1/1/1
  - DONE: 1/0/0/0
- Outputs are decoded from the state register only, so all four flags are glitch-free and defined in every state. There are no latch-like holds.
- Transitions:
  - IDLE→LOAD_UP when `start`=1.
  - LOAD_UP, LOAD_LOW, PASS and SWAP each advance to the next state when `phase_cnt`==DEPTH-1 and `in_valid`=1.
  - DRAIN advances when `phase_cnt`==DEPTH-1. DRAIN does not wait for `in_valid`; it flushes the delay line every cycle.
  - DRAIN→DONE, then DONE→IDLE unconditionally.
- `phase_cnt`:
  - Increments on each `in_valid` in LOAD_UP, LOAD_LOW, PASS and SWAP.
  - Increments every cycle in DRAIN.
  - Wraps to 0 on each phase transition.
  - Holds at 0 in IDLE and DONE.
- `out_valid` is `in_valid` while in SWAP, 1 in DRAIN, and 0 in all other states. This is the only combinational path from input to output.
- `busy` is 0 only in IDLE. `done` is 1 only in DONE.
- `start` outside IDLE is ignored; it is not queued.
- `abort` has priority over all transitions: next state is IDLE and `phase_cnt` becomes 0. `abort` in IDLE has no effect. `abort` and `start` high together in IDLE leaves the block in IDLE.
- `in_valid` in IDLE or DONE is ignored.

## Timing

- Reset (asynchronous assert, synchronous deassert by the clock domain): state = IDLE, `phase_cnt`=0.
  - Outputs during reset: `mode`=1, all flags 0, `out_valid`=0, `busy`=0, `done`=0.
- Reset mid-frame is immediate: outputs go to the IDLE values without waiting for a clock edge.
- Latency: `start` sampled at edge 0 puts the block in LOAD_UP from cycle 1. With `in_valid` continuously high:
  - LOAD_UP: cycles 1..DEPTH
  - LOAD_LOW: cycles DEPTH+1..2·DEPTH
  - PASS: cycles 2·DEPTH+1..3·DEPTH
  - SWAP: cycles 3·DEPTH+1..4·DEPTH
  - DRAIN: cycles 4·DEPTH+1..5·DEPTH
  - DONE: cycle 5·DEPTH+1
  - IDLE: from cycle 5·DEPTH+2
- Minimum start-to-start spacing is 5·DEPTH+2 cycles. `start` is first honoured in the cycle after DONE.
- Gaps in `in_valid` stretch the current phase by exactly the number of gap cycles; the flags are stable across the gap.

## Test plan

- Reset with DEPTH=8: hold `rst_n`=0 → `mode`=1, all flags 0, `busy`=0, `phase_cnt`=0. Assert `rst_n`=0 asynchronously mid-PASS → outputs return to IDLE values before the next edge.
- Full frame with DEPTH=8 and `in_valid`=1 constantly. Start at cycle 0 → required response:
  - flags in each 8-cycle window starting at cycles 1, 9, 17, 25, 33: 1000, 1100, 0100, 0110, 0111
  - `done`=1 at cycle 41 only; `busy`=0 from cycle 42
  - `out_valid`=1 for cycles 25..40
- Gapped input: `in_valid`=0 on every third cycle → each input-driven phase spans 12 cycles; DRAIN still spans 8 cycles; the flag sequence is unchanged.
- `abort` asserted at the 3rd SWAP cycle → IDLE next cycle, `phase_cnt`=0, `done` never pulses. A `start` on the following cycle → LOAD_UP.
- `start` pulsed in PASS and in DONE → ignored; no second frame begins. `start` the cycle after DONE → a new frame begins.
- Boundary with DEPTH=2: a full frame takes 12 cycles; `phase_cnt` wraps 0→1→0 each phase.
